// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pkg
//  Brief    : Shared arbitration constants and onehot-to-index helper.
//  Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

   localparam int ARB_FIXED  = 0;
   localparam int ARB_RR     = 1;
   localparam int MAX_INPUTS = 16;

   // Encodes a onehot vector (up to MAX_INPUTS wide) into its bit index.
   // An all-zero vector encodes to 0; callers qualify with |onehot.
   function automatic logic [3:0] onehot_to_idx(input logic [MAX_INPUTS-1:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_INPUTS; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Fixed-priority or round-robin request arbiter; owns rr_ptr.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int N    = 4,
   parameter  int MODE = ARB_RR,
   localparam int SW   = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] grant_idx,
   output logic [SW-1:0] ptr
);

   logic [SW-1:0]         ptr_q;
   logic [SW-1:0]         ptr_d;
   logic [N-1:0]          grant_d;
   logic [MAX_INPUTS-1:0] oh_pad;

   // Search from the base index (rr_ptr in RR mode, 0 otherwise) with wrap.
   always_comb begin
      int  j;
      int  base;
      logic found;
      grant_d = '0;
      found   = 1'b0;
      j       = 0;
      base    = (MODE == ARB_RR) ? int'(ptr_q) : 0;
      for (int k = 0; k < N; k++) begin
         j = (base + k) % N;
         if (!found && req[j]) begin
            found      = 1'b1;
            grant_d[j] = 1'b1;
         end
      end
   end

   // Encode the winning onehot into an index via the shared helper.
   always_comb begin
      oh_pad         = '0;
      oh_pad[N-1:0]  = grant_d;
      grant_idx      = SW'(onehot_to_idx(oh_pad));
      grant          = grant_d;
   end

   // Next pointer is one past the winner, wrapping after the last channel.
   always_comb begin
      ptr_d = ptr_q;
      if (MODE == ARB_RR && advance) begin
         ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mux_n_to_1_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mux_n_to_1_arb
//  Brief    : N-to-1 registered stream mux with valid/ready handshakes,
//             fixed-priority / round-robin arbitration and forced select.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_n_to_1_arb
   import mux_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 4,
   parameter int SEL_WIDTH  = $clog2(NUM_INPUTS),
   parameter int ARB_MODE   = ARB_RR
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_INPUTS-1:0]            in_valid,
   output logic [NUM_INPUTS-1:0]            in_ready,
   input  logic                             force_en,
   input  logic [SEL_WIDTH-1:0]             force_sel,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [SEL_WIDTH-1:0]             out_sel,
   output logic                             out_valid,
   input  logic                             out_ready
);

   logic [NUM_INPUTS-1:0] force_grant;
   logic [NUM_INPUTS-1:0] arb_grant;
   logic [SEL_WIDTH-1:0]  arb_idx;
   logic [SEL_WIDTH-1:0]  arb_ptr;
   logic [NUM_INPUTS-1:0] grant;
   logic [SEL_WIDTH-1:0]  grant_idx;
   logic [DATA_WIDTH-1:0] grant_data;
   logic                  any_grant;
   logic                  load;
   logic                  advance;

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_WIDTH-1:0]  out_sel_q,   out_sel_d;

   // Forced grant: decoded select qualified by that channel's valid.
   // Out-of-range selects match no channel and grant nothing.
   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_force
      assign force_grant[i] = (force_sel == SEL_WIDTH'(i)) & in_valid[i];
   end

   // Round-robin pointer only moves on an accepted, non-forced transfer.
   assign advance = load & (|arb_grant) & ~force_en;

   rr_arbiter #(
      .N    (NUM_INPUTS),
      .MODE (ARB_MODE)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (in_valid),
      .advance   (advance),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .ptr       (arb_ptr)
   );

   // Final grant selection and handshake; in_ready is forced low during reset.
   always_comb begin
      load      = ~out_valid_q | out_ready;
      grant     = force_en ? force_grant : arb_grant;
      grant_idx = force_en ? force_sel   : arb_idx;
      any_grant = |grant;
      in_ready  = grant & {NUM_INPUTS{load & rst_n}};
   end

   // OR-mux of the granted channel's data; grant is onehot or zero.
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (grant[i]) grant_data = grant_data | in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Output stage next-state: load a new beat or hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      if (load) begin
         out_valid_d = any_grant;
         if (any_grant) begin
            out_data_d = grant_data;
            out_sel_d  = grant_idx;
         end
      end
   end

   // Output stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

   // The arbiter pointer is kept internal; it is sampled here only so the
   // reset value stays observable in simulation without a dangling net.
   logic unused_ok;
   assign unused_ok = ^arb_ptr;

endmodule : mux_n_to_1_arb
`default_nettype wire

// File: tb/tb_mux_n_to_1_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_n_to_1_arb
//  Brief    : Directed scoreboard bench for mux_n_to_1_arb (RR and fixed).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_n_to_1_arb;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*DW-1:0] in_data;
   logic [DW-1:0]   d [N];
   logic [N-1:0]    in_valid;
   logic            force_en;
   logic [SW-1:0]   force_sel;
   logic            out_ready;

   logic [N-1:0]    in_ready_rr, in_ready_fp;
   logic [DW-1:0]   out_data_rr, out_data_fp;
   logic [SW-1:0]   out_sel_rr,  out_sel_fp;
   logic            out_valid_rr, out_valid_fp;

   always #5 clk = ~clk;

   always_comb begin
      in_data = '0;
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = d[i];
   end

   mux_n_to_1_arb #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .ARB_MODE(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_rr), .force_en(force_en), .force_sel(force_sel),
      .out_data(out_data_rr), .out_sel(out_sel_rr), .out_valid(out_valid_rr),
      .out_ready(out_ready));

   mux_n_to_1_arb #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .ARB_MODE(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready_fp), .force_en(force_en), .force_sel(force_sel),
      .out_data(out_data_fp), .out_sel(out_sel_fp), .out_valid(out_valid_fp),
      .out_ready(out_ready));

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state for the round-robin instance.
   logic [SW+DW-1:0] sbq [$];
   bit               m_valid;
   int               m_ptr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int model_grant();
      int j;
      if (force_en) return in_valid[force_sel] ? int'(force_sel) : -1;
      for (int k = 0; k < N; k++) begin
         j = (m_ptr + k) % N;
         if (in_valid[j]) return j;
      end
      return -1;
   endfunction

   // One clock: check in_ready, update model/scoreboard, clock, check output.
   task automatic cycle();
      int         g;
      bit         ld;
      logic [N-1:0] exp_rdy;
      #1;
      g  = model_grant();
      ld = !m_valid || out_ready;
      exp_rdy = '0;
      if (ld && g >= 0) exp_rdy[g] = 1'b1;
      chk("in_ready", in_ready_rr, exp_rdy);
      if (m_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
      if (ld) begin
         m_valid = (g >= 0);
         if (g >= 0) begin
            sbq.push_back({SW'(g), d[g]});
            if (!force_en) m_ptr = (g + 1) % N;
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", out_valid_rr, m_valid);
      if (m_valid) begin
         chk("sb_depth", sbq.size(), 1);
         if (sbq.size() > 0) chk("beat", {out_sel_rr, out_data_rr}, sbq[0]);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'b1111;
      force_en  = 1'b0;
      force_sel = '0;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) d[i] = '0;
      m_valid = 0;
      m_ptr   = 0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid_rr, 0);
      chk("rst_out_data",  out_data_rr, 0);
      chk("rst_out_sel",   out_sel_rr, 0);
      chk("rst_in_ready",  in_ready_rr, 0);

      // Test 1: async reset mid-stream
      in_valid = 4'b0001;
      d[0]     = 32'hAAAA_0001;
      rst_n    = 1'b1;
      cycle();
      chk("t1_data", out_data_rr, 32'hAAAA_0001);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t1_async_valid", out_valid_rr, 0);
      chk("t1_async_data",  out_data_rr, 0);
      chk("t1_async_rdy",   in_ready_rr, 0);
      sbq.delete();
      m_valid = 0;
      m_ptr   = 0;
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 4'b1111;
      for (int i = 0; i < N; i++) d[i] = 32'h10 + i;

      // Test 2: round-robin with all valid
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("t2_sel",  out_sel_rr, i % 4);
         chk("t2_data", out_data_rr, 32'h10 + (i % 4));
      end

      // Test 3: backpressure on channel 2
      in_valid = 4'b0100;
      cycle();
      chk("t3_data", out_data_rr, 32'h12);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t3_hold", out_data_rr, 32'h12);
         chk("t3_rdy",  in_ready_rr, 0);
      end
      out_ready = 1'b1;
      #1;
      chk("t3_accept_rdy", in_ready_rr, 4'b0100);
      cycle();

      // Test 4: fixed priority instance with channels 1 and 3 valid
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t4_fp_rdy", in_ready_fp, 4'b0010);
         cycle();
         chk("t4_fp_sel",   out_sel_fp, 1);
         chk("t4_fp_valid", out_valid_fp, 1);
      end

      // Test 5: forced select leaves the pointer alone
      force_en  = 1'b1;
      force_sel = 2'd3;
      in_valid  = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t5_sel", out_sel_rr, 3);
      end
      in_valid = 4'b0111;
      cycle();
      chk("t5_novalid", out_valid_rr, 0);
      force_en = 1'b0;
      in_valid = 4'b1111;
      cycle();
      chk("t5_ptr_kept", out_sel_rr, 2);

      // Test 6: wrap between channels 3 and 0 (pointer now 3)
      in_valid = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("t6_wrap", out_sel_rr, (i % 2 == 0) ? 3 : 0);
      end

      in_valid = 4'b0000;
      cycle();
      chk("drain_valid", out_valid_rr, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_mux_n_to_1_arb
`default_nettype wire
